// File: rtl/wb_spiflash_reader.sv
// Wishbone classic slave turning each bus read into one SPI
// READ transaction that returns a little-endian 32-bit word.
module wb_spiflash_reader #(
   parameter int unsigned AW       = 24,
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned CS_GAP   = 2,
   parameter logic [7:0]  READ_CMD = 8'h03
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic [AW-1:0] wb_adr_i,
   input  logic [31:0]   wb_dat_i,
   input  logic [3:0]    wb_sel_i,
   input  logic          wb_we_i,
   input  logic          wb_cyc_i,
   input  logic          wb_stb_i,
   output logic [31:0]   wb_dat_o,
   output logic          wb_ack_o,
   output logic          spi_cs,
   output logic          spi_sclk,
   output logic          spi_mosi,
   input  logic          spi_miso,
   output logic          busy_o
);

   localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

   typedef enum logic [1:0] {
      IDLE,
      XFER,
      GAP
   } state_t;

   state_t        state;
   logic [63:0]   shreg;
   logic [31:0]   rxreg;
   logic [31:0]   rx_next;
   logic [5:0]    bitcnt;
   logic [DW-1:0] divcnt;
   logic [GW-1:0] gapcnt;
   logic          unused;

   // write data, selects and low address bits never matter
   assign unused = ^{wb_dat_i, wb_sel_i, wb_adr_i};

   // receive shifter input: MSB-first stream from the flash
   assign rx_next = {rxreg[30:0], spi_miso};

   // transfer sequencer: bit timing, shifting, ack and cs gap
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state    <= IDLE;
         shreg    <= '0;
         rxreg    <= '0;
         bitcnt   <= '0;
         divcnt   <= '0;
         gapcnt   <= '0;
         wb_dat_o <= '0;
         wb_ack_o <= 1'b0;
         spi_cs   <= 1'b1;
         spi_sclk <= 1'b0;
         spi_mosi <= 1'b0;
         busy_o   <= 1'b0;
      end else begin
         wb_ack_o <= 1'b0;
         unique case (state)
            IDLE: begin
               if (wb_cyc_i && wb_stb_i && !wb_ack_o) begin
                  if (wb_we_i) begin
                     wb_ack_o <= 1'b1;
                  end else begin
                     shreg    <= {READ_CMD, wb_adr_i[23:2],
                                  2'b00, 32'h0};
                     spi_cs   <= 1'b0;
                     spi_sclk <= 1'b0;
                     spi_mosi <= READ_CMD[7];
                     bitcnt   <= '0;
                     divcnt   <= '0;
                     busy_o   <= 1'b1;
                     state    <= XFER;
                  end
               end
            end
            XFER: begin
               if (!wb_cyc_i) begin
                  spi_cs   <= 1'b1;
                  spi_sclk <= 1'b0;
                  spi_mosi <= 1'b0;
                  gapcnt   <= '0;
                  state    <= GAP;
               end else if (divcnt == DIV_LAST) begin
                  divcnt <= '0;
                  if (!spi_sclk) begin
                     spi_sclk <= 1'b1;
                  end else begin
                     rxreg    <= rx_next;
                     spi_sclk <= 1'b0;
                     if (bitcnt == 6'd63) begin
                        wb_dat_o <= {rx_next[7:0], rx_next[15:8],
                                     rx_next[23:16], rx_next[31:24]};
                        wb_ack_o <= 1'b1;
                        spi_cs   <= 1'b1;
                        spi_mosi <= 1'b0;
                        gapcnt   <= '0;
                        state    <= GAP;
                     end else begin
                        bitcnt   <= bitcnt + 6'd1;
                        shreg    <= {shreg[62:0], 1'b0};
                        spi_mosi <= shreg[62];
                     end
                  end
               end else begin
                  divcnt <= divcnt + 1'b1;
               end
            end
            GAP: begin
               if (gapcnt == GAP_LAST) begin
                  busy_o <= 1'b0;
                  state  <= IDLE;
               end else begin
                  gapcnt <= gapcnt + 1'b1;
               end
            end
            default: begin
               busy_o <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_spiflash_reader.sv
// Bench for wb_spiflash_reader: SPI flash model plus
// scoreboard of expected read words.
module tb_wb_spiflash_reader;

   localparam int CLK_DIV = 2;
   localparam int CS_GAP  = 2;
   localparam int LAT     = 128 * CLK_DIV + 1;
   localparam int LIM     = LAT + 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] adr = '0;
   logic [31:0] wdat = '0;
   logic [3:0]  sel = 4'hf;
   logic        we = 1'b0;
   logic        cyc = 1'b0;
   logic        stb = 1'b0;
   logic [31:0] dat;
   logic        ack;
   logic        cs;
   logic        sclk;
   logic        mosi;
   logic        miso = 1'b0;
   logic        busy;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_dat = '0;

   int          fcnt = 0;
   logic [31:0] fin = '0;
   logic [7:0]  fcmd = '0;
   logic [23:0] fadr = '0;
   int          cs_hi = 0;
   int          last_gap = 0;

   always #5 clk = ~clk;

   wb_spiflash_reader #(
      .AW(24),
      .CLK_DIV(CLK_DIV),
      .CS_GAP(CS_GAP),
      .READ_CMD(8'h03)
   ) dut (
      .wb_clk_i(clk),
      .wb_rst_i(rst),
      .wb_adr_i(adr),
      .wb_dat_i(wdat),
      .wb_sel_i(sel),
      .wb_we_i(we),
      .wb_cyc_i(cyc),
      .wb_stb_i(stb),
      .wb_dat_o(dat),
      .wb_ack_o(ack),
      .spi_cs(cs),
      .spi_sclk(sclk),
      .spi_mosi(mosi),
      .spi_miso(miso),
      .busy_o(busy)
   );

   function automatic logic [7:0] fb(input logic [23:0] a);
      logic [7:0] r;
      case (a)
         24'h100000: r = 8'h13;
         24'h100001: r = 8'h05;
         24'h100002: r = 8'h00;
         24'h100003: r = 8'h00;
         default:    r = a[7:0] ^ a[15:8] ^ 8'h5a;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] fword(input logic [23:0] a);
      logic [23:0] b;
      b = {a[23:2], 2'b00};
      return {fb(b + 24'd3), fb(b + 24'd2),
              fb(b + 24'd1), fb(b)};
   endfunction

   // mode-0 flash: sample on rise, drive data on fall
   always @(posedge sclk or negedge sclk or posedge cs) begin
      int j;
      logic [7:0] b;
      if (cs) begin
         fcnt = 0;
         miso = 1'b0;
      end else if (sclk) begin
         fin  = {fin[30:0], mosi};
         fcnt = fcnt + 1;
         if (fcnt == 32) begin
            fcmd = fin[31:24];
            fadr = fin[23:0];
         end
      end else if (fcnt >= 32 && fcnt < 64) begin
         j    = fcnt - 32;
         b    = fb(fadr + 24'(j / 8));
         miso = b[7 - (j % 8)];
      end
   end

   // length of each cs-high stretch
   always @(negedge clk) begin
      if (cs === 1'b1) begin
         cs_hi = cs_hi + 1;
      end else begin
         if (cs_hi > 0) last_gap = cs_hi;
         cs_hi = 0;
      end
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_rd(input logic [23:0] a);
      adr = a;
      we  = 1'b0;
      cyc = 1'b1;
      stb = 1'b1;
      exp_q.push_back(fword(a));
   endtask

   task automatic drop();
      cyc = 1'b0;
      stb = 1'b0;
   endtask

   task automatic wait_ack(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!ack && n < LIM);
      if (!ack) chk("ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic pop_chk(input string tag);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk(tag, dat, e);
         last_dat = e;
      end
   endtask

   initial begin
      int n;
      logic got_ack;

      repeat (3) tick();
      chk("rst_cs", cs, 1);
      chk("rst_sclk", sclk, 0);
      chk("rst_mosi", mosi, 0);
      chk("rst_ack", ack, 0);
      chk("rst_dat", dat, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      repeat (2) tick();

      start_rd(24'h100000);
      wait_ack(n);
      chk("rd_lat", n, LAT);
      chk("rd_cmd", fcmd, 8'h03);
      chk("rd_adr", fadr, 24'h100000);
      pop_chk("rd_data");
      chk("rd_const", dat, 32'h00000513);
      chk("cs_on_ack", cs, 1);
      drop();
      tick();
      chk("ack_pulse", ack, 0);

      repeat (4) tick();
      start_rd(24'h100003);
      wait_ack(n);
      chk("unal_adr", fadr, 24'h100000);
      pop_chk("unal_data");
      drop();
      tick();

      repeat (4) tick();
      adr  = 24'h000010;
      wdat = 32'hdeadbeef;
      we   = 1'b1;
      cyc  = 1'b1;
      stb  = 1'b1;
      tick();
      chk("wr_ack", ack, 1);
      chk("wr_cs", cs, 1);
      chk("wr_sclk", sclk, 0);
      chk("wr_busy", busy, 0);
      drop();
      we = 1'b0;
      tick();
      chk("wr_ack_pulse", ack, 0);
      chk("wr_cs2", cs, 1);
      chk("wr_sclk2", sclk, 0);

      repeat (4) tick();
      start_rd(24'h000000);
      wait_ack(n);
      pop_chk("b2b0_data");
      adr = 24'h000004;
      exp_q.push_back(fword(24'h000004));
      wait_ack(n);
      chk("b2b1_adr", fadr, 24'h000004);
      pop_chk("b2b1_data");
      chk("b2b_gap", last_gap >= CS_GAP, 1);
      drop();
      tick();

      repeat (4) tick();
      start_rd(24'h000200);
      n = 0;
      while (fcnt < 20 && n < LIM) begin
         tick();
         n++;
      end
      chk("abort_reach", fcnt >= 20, 1);
      chk("abort_busy", busy, 1);
      drop();
      tick();
      chk("abort_cs", cs, 1);
      chk("abort_sclk", sclk, 0);
      chk("abort_ack", ack, 0);
      chk("abort_dat", dat, last_dat);
      void'(exp_q.pop_front());
      got_ack = 1'b0;
      repeat (8) begin
         tick();
         if (ack) got_ack = 1'b1;
      end
      chk("abort_noack", got_ack, 0);
      start_rd(24'h000104);
      wait_ack(n);
      chk("post_abort_adr", fadr, 24'h000104);
      pop_chk("post_abort_data");
      drop();
      tick();

      repeat (4) tick();
      start_rd(24'h100000);
      n = 0;
      while (fcnt < 40 && n < LIM) begin
         tick();
         n++;
      end
      chk("rst_mid_reach", fcnt >= 40, 1);
      rst = 1'b1;
      #1;
      chk("rstm_cs", cs, 1);
      chk("rstm_sclk", sclk, 0);
      chk("rstm_mosi", mosi, 0);
      chk("rstm_ack", ack, 0);
      chk("rstm_dat", dat, 0);
      chk("rstm_busy", busy, 0);
      drop();
      void'(exp_q.pop_front());
      tick();
      rst = 1'b0;
      tick();
      start_rd(24'h100000);
      wait_ack(n);
      chk("post_rst_lat", n, LAT);
      pop_chk("post_rst_data");
      drop();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
